// File: rtl/rgmii_rx_frame_ctrl.sv
// Receive frame sequencer: finds preamble/SFD in the raw RGMII byte stream, strips
// preamble, SFD and FCS, checks length and CRC32, and keeps saturating statistics.
module rgmii_rx_frame_ctrl #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                  rx_mac_aclk,
  input  logic                  rx_reset,
  input  logic                  inband_link_status,
  input  logic [1:0]            inband_clock_speed,
  input  logic [7:0]            rx_axis_rgmii_tdata,
  input  logic                  rx_axis_rgmii_tvalid,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  rx_busy,
  output logic [STAT_WIDTH-1:0] stat_good,
  output logic [STAT_WIDTH-1:0] stat_bad,
  output logic [STAT_WIDTH-1:0] stat_pre_err
);

  localparam int              LW          = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [LW-1:0]   LEN_HOLD    = LW'(5);
  localparam logic [LW-1:0]   LEN_MIN     = LW'(MIN_FRAME_LEN);
  localparam logic [LW-1:0]   LEN_MAX     = LW'(MAX_FRAME_LEN);
  localparam logic [LW-1:0]   LEN_SAT     = LW'(MAX_FRAME_LEN + 1);
  localparam logic [31:0]     CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]     CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ din[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else               c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + STAT_WIDTH'(1);
  endfunction

  state_e                state_q;
  logic [1:0]            gap_q, gap_d;
  logic [LW-1:0]         len_q, len_d;
  logic [31:0]           crc_q, crc_d;
  logic [7:0]            hold_q [5];
  logic [7:0]            tdata_q;
  logic                  tvalid_q, tlast_q, tuser_q;
  logic [STAT_WIDTH-1:0] good_q, bad_q, pre_err_q;
  logic                  byte_vld, link_dn, eof_det, has_hold, frame_ok;

  // Input qualification, gap tracking and next values of length and CRC.
  always_comb begin
    byte_vld = rx_axis_rgmii_tvalid & inband_link_status;
    link_dn  = ~inband_link_status;
    // 10/100 presents a byte every other cycle, so one idle cycle is normal there.
    eof_det  = ~byte_vld & ((inband_clock_speed == 2'b10) | (gap_q != 2'd0));
    if (byte_vld) gap_d = 2'd0;
    else          gap_d = (gap_q == 2'd2) ? gap_q : gap_q + 2'd1;
    len_d    = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
    crc_d    = crc32_byte(crc_q, rx_axis_rgmii_tdata);
    has_hold = (len_q >= LEN_HOLD);
    frame_ok = has_hold & (crc_q == CRC_RESIDUE) & (len_q >= LEN_MIN);
  end

  // Frame FSM with hold buffer, registered stream outputs and statistics.
  always_ff @(posedge rx_mac_aclk) begin
    if (rx_reset) begin
      state_q   <= S_IDLE;
      gap_q     <= 2'd0;
      len_q     <= '0;
      crc_q     <= CRC_INIT;
      for (int i = 0; i < 5; i++) hold_q[i] <= 8'h00;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
      pre_err_q <= '0;
    end else begin
      gap_q    <= gap_d;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (byte_vld) begin
            if (rx_axis_rgmii_tdata == 8'h55) begin
              state_q <= S_PRE;
            end else begin
              state_q   <= S_DROP;
              pre_err_q <= sat_inc(pre_err_q);
            end
          end
        end
        S_PRE: begin
          if (link_dn) begin
            state_q <= S_IDLE;
          end else if (byte_vld) begin
            if (rx_axis_rgmii_tdata == 8'hD5) begin
              state_q <= S_DATA;
              len_q   <= '0;
              crc_q   <= CRC_INIT;
            end else if (rx_axis_rgmii_tdata != 8'h55) begin
              state_q   <= S_DROP;
              pre_err_q <= sat_inc(pre_err_q);
            end
          end else if (eof_det) begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (link_dn || eof_det) begin
            state_q  <= S_IDLE;
            tvalid_q <= has_hold;
            tlast_q  <= has_hold;
            tuser_q  <= has_hold & (link_dn | ~frame_ok);
            tdata_q  <= has_hold ? hold_q[4] : 8'h00;
            if (!link_dn && frame_ok) good_q <= sat_inc(good_q);
            else                      bad_q  <= sat_inc(bad_q);
          end else if (byte_vld) begin
            crc_q    <= crc_d;
            len_q    <= len_d;
            tvalid_q <= has_hold;
            tdata_q  <= has_hold ? hold_q[4] : 8'h00;
            if (len_q == LEN_MAX) begin
              tlast_q <= 1'b1;
              tuser_q <= 1'b1;
              bad_q   <= sat_inc(bad_q);
              state_q <= S_DROP;
            end else begin
              hold_q[0] <= rx_axis_rgmii_tdata;
              for (int i = 1; i < 5; i++) hold_q[i] <= hold_q[i-1];
            end
          end
        end
        S_DROP: begin
          if (link_dn || eof_det) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign rx_busy       = (state_q != S_IDLE);
  assign stat_good     = good_q;
  assign stat_bad      = bad_q;
  assign stat_pre_err  = pre_err_q;

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Randomised bench for rgmii_rx_frame_ctrl: a frame-level reference model predicts the
// stripped output beats and statistics for every byte burst that is driven.
module tb_rgmii_rx_frame_ctrl;

  localparam int MIN = 64;
  localparam int MAX = 1518;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         cyc;
    logic [9:0] b;
  } beat_t;

  logic        clk, rst, link, valid;
  logic [1:0]  speed;
  logic [7:0]  data;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, busy;
  logic [31:0] s_good, s_bad, s_pre;

  int    vec = 0, miss = 0, cyc = 0;
  int    sfd_cyc, last_cyc, cut_cyc = -100;
  int    mg = 0, mb = 0, mp = 0;
  logic  cut_or;
  bq_t   stim_q, pay_q;
  logic [9:0] exp_q[$];
  beat_t cap_q[$];

  rgmii_rx_frame_ctrl #(.MIN_FRAME_LEN(MIN), .MAX_FRAME_LEN(MAX), .STAT_WIDTH(32)) dut (
    .rx_mac_aclk(clk), .rx_reset(rst), .inband_link_status(link), .inband_clock_speed(speed),
    .rx_axis_rgmii_tdata(data), .rx_axis_rgmii_tvalid(valid),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .rx_busy(busy),
    .stat_good(s_good), .stat_bad(s_bad), .stat_pre_err(s_pre)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_tvalid) cap_q.push_back('{cyc, {m_tlast, m_tuser & m_tlast, m_tdata}});
    if (cyc == cut_cyc)
      cut_or = |{m_tdata, m_tvalid, m_tlast, m_tuser, busy, s_good, s_bad, s_pre};
  end

  // Standard Ethernet CRC32 (byte-wise, final complement) over the first n bytes of pay_q.
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int len, input bit bad_fcs);
    logic [31:0] f;
    stim_q.delete();
    pay_q.delete();
    repeat (7) stim_q.push_back(8'h55);
    stim_q.push_back(8'hD5);
    for (int i = 0; i < len - 4; i++) pay_q.push_back(8'($urandom));
    f = crc32(len - 4);
    for (int i = 0; i < 4 && pay_q.size() < len; i++) pay_q.push_back(f[8*i +: 8]);
    if (bad_fcs && len >= 4) pay_q[len-1] = pay_q[len-1] ^ 8'h01;
    foreach (pay_q[i]) stim_q.push_back(pay_q[i]);
  endtask

  // A received frame ends: everything except the trailing four FCS bytes is delivered.
  task automatic frame_end(input bit abort);
    int n;
    bit user;
    n = pay_q.size();
    if (n >= 5) begin
      user = abort || (n < MIN) || (crc32(n - 4) !== {pay_q[n-1], pay_q[n-2], pay_q[n-3], pay_q[n-4]});
      for (int j = 0; j < n - 5; j++) exp_q.push_back({2'b00, pay_q[j]});
      exp_q.push_back({1'b1, user, pay_q[n-5]});
      if (user) mb++;
      else mg++;
    end else begin
      mb++;
    end
  endtask

  // kind 1: link drops at byte cut for the rest of the burst; kind 2: reset replaces byte cut.
  task automatic model_burst(input int cut, input int kind);
    int st;
    logic [7:0] b;
    st = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (i == cut && kind == 2) begin
        if (st == 2) for (int j = 0; j < pay_q.size() - 5; j++) exp_q.push_back({2'b00, pay_q[j]});
        mg = 0; mb = 0; mp = 0; st = 0;
        continue;
      end
      if (i == cut && kind == 1) begin
        if (st == 2) frame_end(1'b1);
        st = 4;
      end
      b = stim_q[i];
      case (st)
        0: if (b == 8'h55) st = 1; else begin st = 3; mp++; end
        1: if (b == 8'hD5) begin st = 2; pay_q.delete(); end
           else if (b != 8'h55) begin st = 3; mp++; end
        2: begin
          pay_q.push_back(b);
          if (pay_q.size() == MAX + 1) begin
            for (int j = 0; j < MAX - 5; j++) exp_q.push_back({2'b00, pay_q[j]});
            exp_q.push_back({2'b11, pay_q[MAX-5]});
            mb++;
            st = 3;
          end
        end
        default: ;
      endcase
    end
    if (st == 2) frame_end(1'b0);
  endtask

  task automatic send_burst(input bit fast, input int cut, input int kind, input int ifg);
    cut_cyc = -100;
    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) speed = fast ? 2'b10 : 2'b01;
      valid = 1'b1;
      data  = stim_q[i];
      rst   = (i == cut && kind == 2);
      if (i == cut && kind == 1) link = 1'b0;
      if (i == cut) cut_cyc = cyc + 1;
      if (i == 7) sfd_cyc = cyc + 1;
      last_cyc = cyc + 1;
      if (!fast) begin
        @(posedge clk); #1;
        valid = 1'b0;
        rst   = 1'b0;
      end
    end
    @(posedge clk); #1;
    valid = 1'b0;
    rst   = 1'b0;
    repeat (ifg) @(posedge clk);
    #1 link = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if ({m_tdata, m_tvalid, m_tlast, m_tuser, busy, s_good, s_bad, s_pre} !== '0)
      $display("FAIL reset_held: outputs %h, want all zero", {m_tdata, m_tvalid, m_tlast, m_tuser, busy, s_good, s_bad, s_pre});
    if ({m_tdata, m_tvalid, m_tlast, m_tuser, busy, s_good, s_bad, s_pre} !== '0) miss++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec++;
    if ({m_tdata, m_tvalid, m_tlast, m_tuser, busy, s_good, s_bad, s_pre} !== '0) begin
      miss++;
      $display("FAIL reset_after: outputs nonzero (busy=%b good=%0d)", busy, s_good);
    end
  endtask

  task automatic test_good_1g();
    cap_q.delete(); exp_q.delete();
    build(64, 1'b0);
    model_burst(-1, 0);
    send_burst(1'b1, -1, 0, 8);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL good_1g beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL good_1g beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL good_1g stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
    if (cap_q.size() > 0) begin
      vec++;
      if (cap_q[0].cyc - sfd_cyc !== 6) begin miss++; $display("FAIL good_1g latency: got %0d want 6", cap_q[0].cyc - sfd_cyc); end
      vec++;
      if (cap_q[$].cyc !== last_cyc + 1) begin miss++; $display("FAIL good_1g tlast_cycle: got %0d want %0d", cap_q[$].cyc, last_cyc + 1); end
    end
  endtask

  task automatic test_gapped_100();
    cap_q.delete(); exp_q.delete();
    model_burst(-1, 0);
    send_burst(1'b0, -1, 0, 8);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL gapped beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL gapped beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL gapped stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
  endtask

  task automatic test_bad_frames();
    cap_q.delete(); exp_q.delete();
    build(64, 1'b1);   model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    build(40, 1'b0);   model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    build(1519, 1'b0); model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    build(3, 1'b0);    model_burst(-1, 0); send_burst(1'b0, -1, 0, 6);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL bad_frames beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL bad_frames beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL bad_frames stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
  endtask

  task automatic test_pre_err();
    cap_q.delete(); exp_q.delete();
    stim_q.delete();
    stim_q.push_back(8'h55); stim_q.push_back(8'h55); stim_q.push_back(8'hA5);
    repeat (20) stim_q.push_back(8'($urandom));
    model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    build(64, 1'b0); model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL pre_err beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL pre_err beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL pre_err stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
  endtask

  task automatic test_link_drop();
    cap_q.delete(); exp_q.delete();
    build(64, 1'b0);
    model_burst(8 + 29, 1);
    send_burst(1'b1, 8 + 29, 1, 6);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL link_drop beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL link_drop beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL link_drop stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
    if (cap_q.size() > 0) begin
      vec++;
      if (cap_q[$].cyc !== cut_cyc) begin miss++; $display("FAIL link_drop tlast_cycle: got %0d want %0d", cap_q[$].cyc, cut_cyc); end
    end
  endtask

  task automatic test_reset_mid();
    cap_q.delete(); exp_q.delete();
    cut_or = 1'bx;
    build(64, 1'b0);
    model_burst(8 + 29, 2);
    send_burst(1'b1, 8 + 29, 2, 6);
    vec++;
    if (cut_or !== 1'b0) begin miss++; $display("FAIL reset_mid outputs: got or=%b want 0", cut_or); end
    build(64, 1'b0); model_burst(-1, 0); send_burst(1'b1, -1, 0, 6);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL reset_mid beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL reset_mid beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL reset_mid stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
  endtask

  task automatic test_back_to_back();
    bit fast;
    cap_q.delete(); exp_q.delete();
    for (int f = 0; f < 16; f++) begin
      fast = $urandom_range(0, 1) == 1;
      build($urandom_range(1, 90), $urandom_range(0, 3) == 0);
      model_burst(-1, 0);
      send_burst(fast, -1, 0, 0);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    vec++;
    if (cap_q.size() !== exp_q.size()) begin miss++; $display("FAIL back_to_back beats: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      vec++;
      if (cap_q[i].b !== exp_q[i]) begin miss++; $display("FAIL back_to_back beat %0d: got %h want %h", i, cap_q[i].b, exp_q[i]); end
    end
    vec++;
    if ({s_good, s_bad, s_pre} !== {mg, mb, mp}) begin miss++; $display("FAIL back_to_back stats: got %0d/%0d/%0d want %0d/%0d/%0d", s_good, s_bad, s_pre, mg, mb, mp); end
  endtask

  initial begin
    rst = 1'b1; link = 1'b1; speed = 2'b10; valid = 1'b0; data = 8'h00; cut_or = 1'b0;
    test_reset();
    test_good_1g();
    test_gapped_100();
    test_bad_frames();
    test_pre_err();
    test_link_drop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_frame_ctrl.md
# rgmii_rx_frame_ctrl

Receive frame sequencer that sits directly after the RGMII receive datapath on `rx_mac_aclk`. It takes the raw byte stream (`tdata`/`tvalid`, no framing) and recognises the preamble and SFD. It delimits frames using inter-frame gaps, checks length and Ethernet FCS, and strips the preamble, SFD and FCS. The result is an AXI-Stream frame output with `tlast`/`tuser` for the MAC/FIFO layer, plus saturating receive statistics.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64: minimum legal length in bytes, measured after the SFD and including the FCS.
- `MAX_FRAME_LEN`, 1518: maximum legal length in bytes, measured the same way.
- `STAT_WIDTH`, 32: width of each statistics counter.

Ports (clock and reset first):
- `rx_mac_aclk`  in  1  sole clock for the block.
- `rx_reset`  in  1  reset; synchronous, active-high.
- `inband_link_status`  in  1  link up (1) / down (0).
- `inband_clock_speed`  in  2  2'b10 selects 1 Gbps; any other value selects 10/100 Mbps.
- `rx_axis_rgmii_tdata`  in  8  raw received byte.
- `rx_axis_rgmii_tvalid`  in  1  raw byte valid. Asserted every cycle at 1 Gbps and every other cycle at 10/100 Mbps.
- `m_axis_tdata`  out  8  frame byte, registered.
- `m_axis_tvalid`  out  1  output byte valid. There is no `tready`: the sink must accept every beat.
- `m_axis_tlast`  out  1  marks the last byte of the frame (before the FCS).
- `m_axis_tuser`  out  1  bad-frame flag; meaningful only when `tlast` is 1.
- `rx_busy`  out  1  high while the FSM is in PREAMBLE, DATA or DROP.
- `stat_good`  out  STAT_WIDTH  count of good frames.
- `stat_bad`  out  STAT_WIDTH  count of frames with a bad FCS, runt, oversize or abort.
- `stat_pre_err`  out  STAT_WIDTH  count of preamble/SFD errors.

## Operation
- **End-of-frame (EOF) detection.** EOF is detected when `tvalid` is low for one cycle (1 Gbps) or for two consecutive cycles (10/100 Mbps). A gap counter is cleared on every valid byte.
- **IDLE state.**
  - Valid byte 0x55 → PREAMBLE.
  - Any other valid byte → DROP and increment `stat_pre_err`.
  - IDLE never waits for EOF.
- **PREAMBLE state.**
  - 0x55 → stay in PREAMBLE.
  - 0xD5 → DATA; clear the length counter; set the CRC register to 0xFFFFFFFF; empty the 5-byte hold buffer.
  - Any other byte → DROP and increment `stat_pre_err`.
  - EOF → IDLE with no counter change.
- **DATA state.**
  - On each valid byte: increment the length counter (saturating at MAX_FRAME_LEN+1) and update the CRC32.
  - CRC32 uses the reflected polynomial 0xEDB88320 and processes bytes LSB-first.
  - Each byte is shifted into the hold buffer. If the buffer already holds 5 bytes, the oldest byte is emitted (tvalid=1, tlast=0).
- **DATA, EOF.** Go to IDLE.
  - If length ≥ 5: emit the oldest held byte with tlast=1. Set tuser=1 if the CRC register ≠ 0xDEBB20E3 or length < MIN_FRAME_LEN.
  - If length < 5: nothing is emitted.
  - Increment `stat_good` if tuser=0, otherwise `stat_bad`. A frame with length < 5 counts as bad.
- **DATA, oversize.** When a valid byte makes length = MAX_FRAME_LEN+1:
  - Emit the oldest held byte with tlast=1, tuser=1.
  - Flush the buffer, increment `stat_bad` and go to DROP.
- **DROP state.** Ignore bytes; on EOF → IDLE.
- **Link low.**
  - In DATA: same as the EOF path but with tuser forced to 1.
  - In any other state: go to IDLE.
  - While the link is low, valid bytes are ignored.
- **Priority within one cycle.** Reset > link-down abort > oversize > EOF > normal byte.
- **Counters.** Saturate at all-ones.

## Timing
- **Reset values.** While `rx_reset` is high, and on the cycle after it, all outputs are 0. The FSM is in IDLE and the buffer and gap counter are empty.
- **Reset mid-frame.** The remaining bytes of the interrupted frame are handled by the IDLE rules (usually → DROP). The next frame after EOF is received normally.
- **Data latency.**
  - The byte that arrives as the 6th byte after the SFD, at cycle t, causes the 1st frame byte to appear at t+1.
  - In general, output byte k appears one cycle after input byte k+5.
- **Frame-end timing.**
  - tlast appears one cycle after the cycle in which EOF is detected.
  - The oversize/abort tlast appears one cycle after the triggering byte or link-low cycle.
  - Statistics update on the same edge as tlast.
- **Back-to-back frames.** `tvalid` is never asserted on two beats closer together than the input byte spacing. A new frame may begin in the cycle after EOF.

## Test plan
- **1 Gbps good frame.** 7×0x55, 0xD5, then a 64-byte frame with a correct FCS, continuous tvalid → 60 output beats with tlast on beat 60, tuser=0, `stat_good`=1, first beat 6 cycles after the SFD.
- **10/100 gapped stream.** Speed 2'b01, the same frame with tvalid on alternate cycles → identical 60 beats; no false EOF on single-cycle gaps.
- **Corrupted FCS.** Flip bit 0 of the final FCS byte → tlast with tuser=1, `stat_bad`=1.
- **Runt and oversize.**
  - 40-byte frame with a correct FCS → 36 beats, tuser=1.
  - 1519-byte frame → tlast+tuser when byte 1519 is received, then DROP until EOF, `stat_bad`=2.
- **Preamble error.** 0x55, 0x55, 0xA5, … → no output, `stat_pre_err`=1; the following good frame is received correctly.
- **Link drop and reset mid-frame.**
  - Link low at byte 30 → tlast tuser=1 on the next cycle.
  - `rx_reset` pulsed at byte 30 → no tlast, all outputs 0, and the next frame is good.
